// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16-to-1 single-bit mux tree: steps the select through every
// channel, waits a settle time, samples, and publishes the assembled word with a done pulse.
module mux_scan_ctrl #(
   parameter int SEL_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  cont,
   input  logic                  mux_out,
   output logic [SEL_W-1:0]      mux_sel,
   output logic [(1<<SEL_W)-1:0] data_out,
   output logic                  done,
   output logic                  busy
);

   localparam int               N_CH       = 1 << SEL_W;
   localparam logic [7:0]       SETTLE_CNT = 8'(SETTLE);
   localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE
   } state_e;

   // With no settle time every channel goes straight to its sampling cycle.
   localparam state_e FIRST_ST = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

   state_e           state_q;
   logic [7:0]       cnt_q;
   logic [SEL_W-1:0] sel_q;
   logic [N_CH-1:0]  shadow_q;
   logic [N_CH-1:0]  data_q;
   logic             done_q;
   logic             busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         // NOTE: the shadow word is a flop vector, not a RAM, so it can and does take the reset.
         shadow_q <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch reads pre-edge values of sel_q and shadow_q.
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  sel_q   <= '0;
                  cnt_q   <= SETTLE_CNT;
                  state_q <= FIRST_ST;
               end
            end
            ST_SETTLE: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               shadow_q[sel_q] <= mux_out;
               cnt_q           <= SETTLE_CNT;
               if (sel_q != LAST_CH) begin
                  sel_q   <= sel_q + SEL_W'(1);
                  state_q <= FIRST_ST;
               end else begin
                  // The last bit bypasses the shadow so the word is published on this very edge.
                  data_q  <= {mux_out, shadow_q[N_CH-2:0]};
                  done_q  <= 1'b1;
                  sel_q   <= '0;
                  if (cont) begin
                     state_q <= FIRST_ST;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mux_sel  = sel_q;
   assign data_out = data_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 0 and settle 1) each driven by a modelled
// mux tree; expectations come from the scan rules (N_CH*(settle+1) cycles, word = mux pattern).
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

   localparam int N_CH = 16;

   logic        clk;
   logic        rst_n;
   logic        start    [2];
   logic        cont     [2];
   logic [15:0] pat      [2];
   logic        mux_out0;
   logic        mux_out1;
   logic [3:0]  mux_sel  [2];
   logic [15:0] data_out [2];
   logic        done     [2];
   logic        busy     [2];

   int checks = 0;
   int errors = 0;

   // Instance index equals its settle setting.
   mux_scan_ctrl #(.SEL_W(4), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]), .mux_out(mux_out0),
      .mux_sel(mux_sel[0]), .data_out(data_out[0]), .done(done[0]), .busy(busy[0]));

   mux_scan_ctrl #(.SEL_W(4), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]), .mux_out(mux_out1),
      .mux_sel(mux_sel[1]), .data_out(data_out[1]), .done(done[1]), .busy(busy[1]));

   // Combinational mux tree: presents bit mux_sel of the current pattern.
   assign mux_out0 = pat[0][mux_sel[0]];
   assign mux_out1 = pat[1][mux_sel[1]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int          d;
      logic [15:0] pattern;
      logic [15:0] exp_data;
      int          exp_cyc;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Counts edges until done on instance d; gives up after a bounded number of cycles.
   task automatic wait_done(input int d, output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 300) begin
         @(posedge clk);
         cyc++;
         #1;
         got = done[d];
      end
   endtask

   // One single-shot scan with full per-cycle tracking of select, busy and data_out.
   task automatic do_scan(input int d, input logic [15:0] p, input logic [15:0] exp_data,
                          input int exp_cyc);
      int          cyc, bad_sel, bad_busy, chg;
      bit          got;
      logic [15:0] prev;
      @(negedge clk);
      pat[d]   = p;
      cont[d]  = 1'b0;
      start[d] = 1'b1;
      @(posedge clk);
      #1 start[d] = 1'b0;
      prev     = data_out[d];
      cyc      = 0;
      got      = 1'b0;
      bad_sel  = (mux_sel[d] !== 4'd0) ? 1 : 0;
      bad_busy = (busy[d] !== 1'b1) ? 1 : 0;
      chg      = 0;
      while (!got && cyc < 300) begin
         @(posedge clk);
         cyc++;
         #1;
         got = done[d];
         if (!got) begin
            if (data_out[d] !== prev) chg++;
            if (busy[d] !== 1'b1) bad_busy++;
            if (int'(mux_sel[d]) != cyc / (d + 1)) bad_sel++;
         end
      end
      check($sformatf("scan%0d_cycles", d), cyc, exp_cyc);
      check($sformatf("scan%0d_data", d), data_out[d], exp_data);
      check($sformatf("scan%0d_busy_end", d), busy[d], 1'b0);
      check($sformatf("scan%0d_sel_end", d), mux_sel[d], 4'd0);
      check($sformatf("scan%0d_sel_steps", d), bad_sel, 0);
      check($sformatf("scan%0d_busy_during", d), bad_busy, 0);
      check($sformatf("scan%0d_data_stable", d), chg, 0);
      @(posedge clk);
      #1 check($sformatf("scan%0d_done_width", d), done[d], 1'b0);
   endtask

   initial begin
      int          cyc, chg, extra, n;
      bit          got, injected;
      logic [15:0] prev, p, exp_p;

      tbl[0] = '{d: 1, pattern: 16'hA5C3, exp_data: 16'hA5C3, exp_cyc: 32};
      tbl[1] = '{d: 0, pattern: 16'h0001, exp_data: 16'h0001, exp_cyc: 16};
      tbl[2] = '{d: 1, pattern: 16'h8000, exp_data: 16'h8000, exp_cyc: 32};
      tbl[3] = '{d: 0, pattern: 16'hFFFF, exp_data: 16'hFFFF, exp_cyc: 16};
      tbl[4] = '{d: 1, pattern: 16'h0000, exp_data: 16'h0000, exp_cyc: 32};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         cont[i]  = 1'b0;
         pat[i]   = 16'h0000;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst%0d_outputs", i), {data_out[i], mux_sel[i], done[i], busy[i]}, '0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single scans, including the 0xA5C3 / settle 1 and 0x0001 / settle 0 cases.
      for (int i = 0; i < 5; i++) begin
         do_scan(tbl[i].d, tbl[i].pattern, tbl[i].exp_data, tbl[i].exp_cyc);
      end

      // start pulsed at channel 5 of a running scan must be ignored.
      @(negedge clk);
      pat[1]   = 16'h5A3C;
      start[1] = 1'b1;
      @(posedge clk);
      #1 start[1] = 1'b0;
      prev     = data_out[1];
      cyc      = 0;
      got      = 1'b0;
      chg      = 0;
      injected = 1'b0;
      while (!got && cyc < 300) begin
         @(posedge clk);
         cyc++;
         #1;
         got = done[1];
         if (!got && data_out[1] !== prev) chg++;
         if (!got && !injected && mux_sel[1] == 4'd5) begin
            start[1] = 1'b1;
            injected = 1'b1;
         end else begin
            start[1] = 1'b0;
         end
      end
      check("busy_start_injected", injected, 1'b1);
      check("busy_start_cycles", cyc, 32);
      check("busy_start_data", data_out[1], 16'h5A3C);
      check("busy_start_stable", chg, 0);
      extra = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done[1]) extra++;
      end
      check("busy_start_no_extra_done", extra, 0);
      check("busy_start_idle", busy[1], 1'b0);

      // Continuous mode: back-to-back scans, new pattern presented during scan 2.
      @(negedge clk);
      pat[1]   = 16'hFFFF;
      cont[1]  = 1'b1;
      start[1] = 1'b1;
      @(posedge clk);
      #1 start[1] = 1'b0;
      wait_done(1, cyc);
      check("cont_done1_cycles", cyc, 32);
      check("cont_done1_data", data_out[1], 16'hFFFF);
      check("cont_done1_busy", busy[1], 1'b1);
      pat[1] = 16'h1234;
      wait_done(1, cyc);
      check("cont_done2_cycles", cyc, 32);
      check("cont_done2_data", data_out[1], 16'h1234);
      check("cont_done2_busy", busy[1], 1'b1);
      cont[1] = 1'b0;
      wait_done(1, cyc);
      check("cont_done3_cycles", cyc, 32);
      check("cont_done3_busy", busy[1], 1'b0);

      // start held high through a single-shot done restarts on the following edge.
      @(negedge clk);
      pat[1]   = 16'h0F0F;
      start[1] = 1'b1;
      @(posedge clk);
      wait_done(1, cyc);
      check("held_done1_cycles", cyc, 32);
      check("held_done1_busy", busy[1], 1'b0);
      @(posedge clk);
      #1;
      check("held_restart_busy", busy[1], 1'b1);
      check("held_restart_sel", mux_sel[1], 4'd0);
      start[1] = 1'b0;
      wait_done(1, cyc);
      check("held_done2_cycles", cyc, 32);
      check("held_done2_data", data_out[1], 16'h0F0F);

      // Asynchronous reset mid-scan at channel 7, asserted away from any clock edge.
      @(negedge clk);
      pat[1]   = 16'hFFFF;
      start[1] = 1'b1;
      @(posedge clk);
      #1 start[1] = 1'b0;
      cyc = 0;
      while (mux_sel[1] != 4'd7 && cyc < 300) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      check("rst_mid_reached_ch7", mux_sel[1], 4'd7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_data", data_out[1], 16'h0000);
      check("rst_mid_sel", mux_sel[1], 4'd0);
      check("rst_mid_busy", busy[1], 1'b0);
      check("rst_mid_done", done[1], 1'b0);
      extra = 0;
      repeat (3) begin
         @(posedge clk);
         #1 if (done[1]) extra++;
      end
      check("rst_mid_no_done", extra, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_scan(1, 16'hFFFF, 16'hFFFF, 32);

      // Randomized single scans against the rule: word = pattern, latency = 16*(settle+1).
      for (int i = 0; i < 6; i++) begin
         n = int'($urandom_range(0, 1));
         p = 16'($urandom);
         do_scan(n, p, p, N_CH * (n + 1));
      end

      // Randomized continuous runs with a fresh pattern after every done.
      for (int r = 0; r < 3; r++) begin
         int d;
         d = int'($urandom_range(0, 1));
         n = int'($urandom_range(2, 3));
         @(negedge clk);
         p        = 16'($urandom);
         pat[d]   = p;
         cont[d]  = 1'b1;
         start[d] = 1'b1;
         @(posedge clk);
         #1 start[d] = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (k == n - 1) cont[d] = 1'b0;
            exp_p = p;
            wait_done(d, cyc);
            check($sformatf("rnd_cont%0d_cycles", r), cyc, N_CH * (d + 1));
            check($sformatf("rnd_cont%0d_data", r), data_out[d], exp_p);
            check($sformatf("rnd_cont%0d_busy", r), busy[d], (k != n - 1) ? 1'b1 : 1'b0);
            p      = 16'($urandom);
            pat[d] = p;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
